// File: rtl/mmio_pkg.sv
// Shared types and defaults for the MMIO initiator and its slot bus.
package mmio_pkg;
   localparam int SLOT_OFF_W         = 8;
   localparam int DEF_NUM_SLOTS      = 4;
   localparam int DEF_TIMEOUT_CYCLES = 255;

   typedef enum logic [1:0] {
      RESP_OK      = 2'b00,
      RESP_SLVERR  = 2'b01,
      RESP_DECERR  = 2'b10,
      RESP_TIMEOUT = 2'b11
   } resp_err_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_COMPLETE,
      ST_RESP
   } state_e;
endpackage

// File: rtl/mmio_timeout_counter.sv
// Counts ACCESS cycles; expired fires on the cycle the count reaches TIMEOUT_CYCLES.
module mmio_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic arst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   logic [7:0] count;

   // Saturating cycle counter, cleared on each new access.
   always_ff @(posedge clk) begin
      if (!arst_n || clear)
         count <= '0;
      else if (enable && count != 8'hFF)
         count <= count + 8'd1;
   end

   // The current cycle is the (count+1)-th enabled cycle.
   assign expired = enable && ((9'({1'b0, count}) + 9'd1) >= 9'(TIMEOUT_CYCLES));
endmodule

// File: rtl/mmio_initiator.sv
// Single-outstanding MMIO initiator: decodes a request to one slot, waits for
// completion or timeout, then returns one response.
module mmio_initiator
   import mmio_pkg::*;
#(
   parameter int NUM_SLOTS      = DEF_NUM_SLOTS,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                        clk,
   input  logic                        arst_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_write,
   input  logic [31:0]                 req_addr,
   input  logic [31:0]                 req_wdata,
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic [31:0]                 resp_rdata,
   output logic [1:0]                  resp_err,
   output logic [NUM_SLOTS-1:0]        chip_select,
   output logic                        read,
   output logic                        write,
   output logic                        transaction_completed,
   output logic [SLOT_OFF_W-1:0]       addr,
   output logic [31:0]                 wr_data,
   input  logic [NUM_SLOTS-1:0][31:0]  slot_rd_data,
   input  logic [NUM_SLOTS-1:0]        slot_wr_done,
   input  logic [NUM_SLOTS-1:0]        slot_rd_done,
   input  logic [NUM_SLOTS-1:0]        slot_slave_error,
   input  logic [NUM_SLOTS-1:0]        slot_decode_error
);
   localparam int SW = $clog2(NUM_SLOTS);
   localparam int AW = SLOT_OFF_W + SW;

   state_e          state, state_nxt;
   resp_err_e       err_q, err_nxt;
   logic [31:0]     rdata_q, rdata_nxt;
   logic            wr_q;
   logic [AW-1:0]   addr_q;
   logic [31:0]     wdata_q;
   logic            load, bad_addr, hit, expired, cnt_clear, cnt_en, in_access;
   logic [SW-1:0]   slot;
   logic [NUM_SLOTS-1:0] one_hot;

   // Only offset + slot bits are kept; anything above them is a decode error.
   assign bad_addr  = |req_addr[31:AW];
   assign slot      = addr_q[AW-1:SLOT_OFF_W];
   assign hit       = slot_wr_done[slot] | slot_rd_done[slot] |
                      slot_slave_error[slot] | slot_decode_error[slot];
   assign in_access = (state == ST_ACCESS);

   mmio_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .arst_n  (arst_n),
      .clear   (cnt_clear),
      .enable  (cnt_en),
      .expired (expired)
   );

   // Next-state and result capture; completion takes precedence over timeout.
   always_comb begin
      state_nxt = state;
      err_nxt   = err_q;
      rdata_nxt = rdata_q;
      load      = 1'b0;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               load = 1'b1;
               if (bad_addr) begin
                  state_nxt = ST_RESP;
                  err_nxt   = RESP_DECERR;
                  rdata_nxt = '0;
               end else begin
                  state_nxt = ST_ACCESS;
                  cnt_clear = 1'b1;
               end
            end
         end
         ST_ACCESS: begin
            cnt_en = 1'b1;
            if (hit) begin
               state_nxt = ST_COMPLETE;
               if (slot_decode_error[slot]) begin
                  err_nxt   = RESP_DECERR;
                  rdata_nxt = '0;
               end else if (slot_slave_error[slot]) begin
                  err_nxt   = RESP_SLVERR;
                  rdata_nxt = '0;
               end else begin
                  err_nxt   = RESP_OK;
                  rdata_nxt = wr_q ? 32'h0 : slot_rd_data[slot];
               end
            end else if (expired) begin
               state_nxt = ST_COMPLETE;
               err_nxt   = RESP_TIMEOUT;
               rdata_nxt = '0;
            end
         end
         ST_COMPLETE: state_nxt = ST_RESP;
         ST_RESP:     if (resp_ready) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // State, request and response registers.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state   <= ST_IDLE;
         err_q   <= RESP_OK;
         rdata_q <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state   <= state_nxt;
         err_q   <= err_nxt;
         rdata_q <= rdata_nxt;
         if (load) begin
            wr_q    <= req_write;
            addr_q  <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
         end
      end
   end

   // One-hot decode of the registered slot index.
   always_comb begin
      one_hot       = '0;
      one_hot[slot] = 1'b1;
   end

   // Slot-facing outputs come only from registers and are quiet outside ACCESS.
   assign chip_select           = in_access ? one_hot : '0;
   assign write                 = in_access &  wr_q;
   assign read                  = in_access & ~wr_q;
   assign addr                  = in_access ? addr_q[SLOT_OFF_W-1:0] : '0;
   assign wr_data               = in_access ? wdata_q : '0;
   assign transaction_completed = (state == ST_COMPLETE);
   assign req_ready             = (state == ST_IDLE);
   assign resp_valid            = (state == ST_RESP);
   assign resp_rdata            = rdata_q;
   assign resp_err              = err_q;
endmodule

// File: tb/tb_mmio_initiator.sv
// Bench for mmio_initiator: randomized slot behaviour, queue scoreboard.
module tb_mmio_initiator;
   localparam int NS = 4;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              arst_n = 1'b0;
   logic              req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
   logic [31:0]       req_addr = '0, req_wdata = '0;
   logic              req_ready, resp_valid, read, write, transaction_completed;
   logic [31:0]       resp_rdata, wr_data;
   logic [1:0]        resp_err;
   logic [NS-1:0]     chip_select;
   logic [7:0]        addr;
   logic [NS-1:0][31:0] slot_rd_data = '0;
   logic [NS-1:0]     slot_wr_done = '0, slot_rd_done = '0;
   logic [NS-1:0]     slot_slave_error = '0, slot_decode_error = '0;

   always #5 clk = ~clk;

   mmio_initiator #(.NUM_SLOTS(NS), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .arst_n(arst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .chip_select(chip_select), .read(read), .write(write),
      .transaction_completed(transaction_completed),
      .addr(addr), .wr_data(wr_data),
      .slot_rd_data(slot_rd_data), .slot_wr_done(slot_wr_done),
      .slot_rd_done(slot_rd_done), .slot_slave_error(slot_slave_error),
      .slot_decode_error(slot_decode_error)
   );

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  err;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0, n_fail = 0;

   // Current plan for the slot responder: which slot, when it answers, how.
   int          p_slot = 0, p_lat = 1000, p_kind = 0;
   bit          p_bad = 1'b0, p_write = 1'b0;
   logic [31:0] p_addr = '0, p_wdata = '0, p_rdata = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Slot responder: noise on every unselected slot, planned answer on the selected one.
   initial begin
      int acc = 0;
      logic [NS-1:0] sel;
      forever begin
         @(negedge clk);
         slot_wr_done      = NS'($urandom);
         slot_rd_done      = NS'($urandom);
         slot_slave_error  = NS'($urandom);
         slot_decode_error = NS'($urandom);
         for (int i = 0; i < NS; i++) slot_rd_data[i] = $urandom;
         sel = NS'(1) << p_slot;
         slot_wr_done      &= ~sel;
         slot_rd_done      &= ~sel;
         slot_slave_error  &= ~sel;
         slot_decode_error &= ~sel;
         slot_rd_data[p_slot] = p_rdata;
         if (chip_select != '0) acc++; else acc = 0;
         if (acc != 0 && acc == p_lat) begin
            case (p_kind)
               0: if (p_write) slot_wr_done |= sel; else slot_rd_done |= sel;
               1: begin
                  slot_slave_error |= sel;
                  if ($urandom_range(0, 1) == 1) slot_rd_done |= sel;
               end
               default: begin
                  slot_decode_error |= sel;
                  if ($urandom_range(0, 1) == 1) slot_slave_error |= sel;
               end
            endcase
         end
      end
   end

   // Monitor: slot bus must match the plan; responses are scored on handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (arst_n && chip_select != '0) begin
            if (p_bad) check("cs_on_bad_addr", 64'(chip_select), 64'd0);
            else begin
               check("chip_select", 64'(chip_select), 64'(NS'(1) << p_slot));
               check("rd_wr_strobe", 64'({write, read}), p_write ? 64'd2 : 64'd1);
               check("slot_addr", 64'(addr), 64'(p_addr[7:0]));
               check("slot_wdata", 64'(wr_data), 64'(p_wdata));
            end
         end
         if (arst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) check("unexpected_resp", 64'd1, 64'd0);
            else begin
               e = exp_q.pop_front();
               check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
               check("resp_err", 64'(resp_err), 64'(e.err));
            end
         end
      end
   end

   task automatic issue(input logic [31:0] a, input bit wr, input logic [31:0] wd);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (req_ready) break;
      end
      check("req_ready_seen", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   // One transaction: the expected outcome follows from the slot's plan alone.
   task automatic do_txn(input int slot, input logic [7:0] off, input int badbit,
                         input bit wr, input logic [31:0] wd, input logic [31:0] rd,
                         input int lat, input int kind, input int hold);
      exp_t e;
      int   elat, cyc, pulses;
      bit   seen;
      p_slot  = slot;
      p_addr  = {22'b0, 2'(slot), off};
      p_bad   = (badbit >= 0);
      if (p_bad) p_addr[badbit] = 1'b1;
      p_write = wr;
      p_wdata = wd;
      p_rdata = rd;
      p_lat   = lat;
      p_kind  = kind;
      if (p_bad) begin
         e.err = 2'b10; e.rdata = 0; elat = 1;
      end else if (lat > TO) begin
         e.err = 2'b11; e.rdata = 0; elat = TO + 2;
      end else begin
         elat = lat + 2;
         e.rdata = 0;
         case (kind)
            0: begin e.err = 2'b00; e.rdata = wr ? 32'h0 : rd; end
            1: e.err = 2'b01;
            default: e.err = 2'b10;
         endcase
      end
      exp_q.push_back(e);
      issue(p_addr, wr, wd);
      seen = 1'b0;
      pulses = 0;
      for (cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (transaction_completed) pulses++;
         if (resp_valid) begin seen = 1'b1; break; end
      end
      check("resp_latency", seen ? 64'(cyc) : 64'd0, 64'(elat));
      check("tc_pulses", 64'(pulses), p_bad ? 64'd0 : 64'd1);
      if (seen) begin
         repeat (hold) begin
            @(negedge clk);
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_err", 64'(resp_err), 64'(e.err));
            check("hold_rdata", 64'(resp_rdata), 64'(e.rdata));
         end
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   initial begin
      int seen_rv;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_slot_outs", 64'({chip_select, read, write, transaction_completed, addr}), 64'd0);
      check("rst_resp", 64'({resp_valid, resp_err, resp_rdata}), 64'd0);
      arst_n = 1'b1;
      @(posedge clk);
      #1;

      do_txn(1, 8'h04, -1, 1'b1, 32'h1, 32'h0, 3, 0, 0);
      do_txn(2, 8'h10, -1, 1'b0, 32'h0, 32'h1, 3, 0, 3);
      do_txn(3, 8'h40, -1, 1'b0, 32'h0, 32'hDEAD_BEEF, 2, 2, 0);
      do_txn(0, 8'h00, 16, 1'b0, 32'h0, 32'h0, 3, 0, 1);
      do_txn(0, 8'h20, -1, 1'b0, 32'h0, 32'h55, 1000, 0, 1);
      do_txn(2, 8'h08, -1, 1'b0, 32'h0, 32'h1234, TO, 0, 0);

      // Reset while the slot is being accessed: no response may follow.
      p_slot = 1; p_addr = 32'h104; p_bad = 1'b0; p_write = 1'b0;
      p_wdata = 32'h77; p_lat = 1000; p_kind = 0;
      issue(32'h104, 1'b0, 32'h77);
      repeat (2) @(posedge clk);
      #1 arst_n = 1'b0;
      @(negedge clk);
      check("pre_rst_in_access", 64'(chip_select), 64'h2);
      @(negedge clk);
      check("midrst_slot_outs", 64'({chip_select, read, write, transaction_completed}), 64'd0);
      check("midrst_idle", 64'(req_ready), 64'd1);
      arst_n = 1'b1;
      seen_rv = 0;
      repeat (15) begin
         @(negedge clk);
         if (resp_valid) seen_rv++;
      end
      check("midrst_no_resp", 64'(seen_rv), 64'd0);
      @(posedge clk);
      #1;

      for (int t = 0; t < 150; t++) begin
         do_txn($urandom_range(0, NS - 1), 8'($urandom),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 31)) : -1,
                1'($urandom), $urandom, $urandom, $urandom_range(1, TO + 3),
                $urandom_range(0, 2), $urandom_range(0, 3));
      end
      repeat (3) @(posedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mmio_initiator.md
MMIO_INITIATOR -- requirements
Module: mmio_initiator

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: number of slot peripherals; power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum ACCESS cycles before the access is aborted; 8-bit.
REQ-003 SHALL have one clock; reset is synchronous and active-low; ports named clk and arst_n.
REQ-004 Ports:
- clk  in  1  system clock.
- arst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when both high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  [7:0] register offset; [8+SW-1:8] slot index (SW = log2 NUM_SLOTS); bits above must be zero.
- req_wdata  in  32  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when both high.
- resp_rdata  out  32  read data.
- resp_err  out  2  00 OK, 01 slave error, 10 decode error, 11 timeout.
- chip_select  out  NUM_SLOTS  one-hot slot select.
- read, write  out  1 each  slot strobes.
- transaction_completed  out  1  one-cycle release pulse to slot.
- addr  out  8  slot register offset.
- wr_data  out  32  slot write data.
- slot_rd_data  in  NUM_SLOTS x 32  per-slot read data.
- slot_wr_done, slot_rd_done  in  NUM_SLOTS each  per-slot completion.
- slot_slave_error, slot_decode_error  in  NUM_SLOTS each  per-slot errors.

Function
REQ-005 FSM states SHALL be IDLE, ACCESS, COMPLETE, RESP.
REQ-006 In IDLE, req_ready SHALL be 1; all other states SHALL drive req_ready 0.
REQ-007 On accept, the block SHALL register req_write, req_addr and req_wdata.
REQ-008 On accept with nonzero upper address bits, the block SHALL go directly to RESP with resp_err=10, without asserting any slot output.
REQ-009 On any other accept, the block SHALL go to ACCESS and clear the timeout counter.
REQ-010 In ACCESS, the block SHALL hold the selected chip_select bit, exactly one of read/write, addr and wr_data stable from registers; no combinational path from req_* to slot outputs.
REQ-011 In ACCESS, the selected slot SHALL be complete when any of its wr_done, rd_done, slave_error or decode_error is 1; on completion the block SHALL capture the result and go to COMPLETE.
REQ-012 Result capture priority SHALL be: decode_error -> 10; else slave_error -> 01; else OK. resp_rdata SHALL be slot_rd_data for an OK read, else 0.
REQ-013 Inputs from non-selected slots SHALL be ignored.
REQ-014 In ACCESS, the counter SHALL increment each cycle. When it reaches TIMEOUT_CYCLES with no completion, the block SHALL go to COMPLETE with resp_err=11 and resp_rdata=0. Completion in the same cycle SHALL win over timeout.
REQ-015 In COMPLETE (exactly 1 cycle), the block SHALL drive chip_select, read and write to 0, drive transaction_completed 1, then go to RESP.
REQ-016 In RESP, resp_valid SHALL be 1 with resp_rdata and resp_err held stable; on resp_ready the block SHALL go to IDLE. Back-to-back: a new accept is possible in the following cycle.
REQ-017 Latency for a slot with registered done (done visible on the 3rd ACCESS cycle): accept in cycle 0; ACCESS in cycles 1-3; COMPLETE in cycle 4; resp_valid in cycle 5.
REQ-018 Outside ACCESS, chip_select, read and write SHALL be 0. Outside COMPLETE, transaction_completed SHALL be 0.

Reset
REQ-019 On arst_n=0 at a clock edge:
- state -> IDLE; counter -> 0.
- All outputs -> 0, except req_ready, which is 1 once in IDLE.
- Any in-flight access is dropped without a response.
REQ-020 Slots SHALL share arst_n so that no slot remains in a DONE-type state after reset.

Structure
REQ-021 Package mmio_pkg SHALL hold the resp_err enum, the state enum, slot offset width (8) and default NUM_SLOTS/TIMEOUT_CYCLES.
REQ-022 The timeout counter SHALL be sub-module mmio_timeout_counter (clear, enable, expired).

Verification
REQ-023 Write 0x0000_0104, data 0x1 to a gpio-style slot 1:
- chip_select=0010, write=1, addr=0x04 held until wr_done.
- transaction_completed pulses once.
- resp_err=00 in cycle 5.
REQ-024 Read 0x0000_0210 from slot 2 returning 0x1: resp_rdata=0x0000_0001, resp_err=00.
REQ-025 Read 0x0000_0340, where slot 3 raises decode_error: resp_err=10, resp_rdata=0, transaction_completed pulsed.
REQ-026 Request 0x0001_0000: resp_err=10 in cycle 1; chip_select never asserted.
REQ-027 Silent slot, TIMEOUT_CYCLES=8: resp_err=11 after 8 ACCESS cycles. Done arriving on cycle 8 instead yields resp_err=00.
REQ-028 Reset mid-ACCESS: the cycle after, all slot outputs are 0, state is IDLE, and no resp_valid appears. resp_ready held 0 for 3 cycles: response stays stable.
